// File: rtl/sync_ram_arbiter.sv
// sync_ram_arbiter: round-robin arbiter that gives two requesters
// shared access to one single-port synchronous RAM.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   a_req/a_we        requester A access request, write(1)/read(0)
//   a_addr/a_wdata    requester A address and write data
//   a_gnt             A's access goes to the RAM this cycle
//   a_rvalid/a_rdata  A's read result (read issued last cycle)
//   b_*               same set for requester B
//   ram_ce/ram_we     RAM clock enable / write enable
//   ram_addr/wdata    RAM address / write data
//   ram_rdata         RAM registered read data
module sync_ram_arbiter #(
  parameter int ADDR_BITS = 2,
  parameter int WIDTH     = 18,
  parameter int EXPONENT  = -12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WIDTH-1:0]     a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [WIDTH-1:0]     b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WIDTH-1:0]     b_rdata,
  output logic                 ram_ce,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [WIDTH-1:0]     ram_wdata,
  input  logic [WIDTH-1:0]     ram_rdata
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_A    = 2'd1,
    TAG_B    = 2'd2
  } tag_e;

  last_e prio_q, prio_d;
  tag_e  tag_q, tag_d;

  // Data words carry a fixed binary exponent; nothing here scales them.
  logic [31:0] unused_exp;
  assign unused_exp = EXPONENT;

  // Grants are purely combinational; reset masks them.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (a_req && !b_req): a_gnt = 1'b1;
        (b_req && !a_req): b_gnt = 1'b1;
        (a_req && b_req): begin
          a_gnt = (prio_q == LAST_B);
          b_gnt = (prio_q == LAST_A);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_ce    = a_gnt | b_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (a_gnt) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (b_gnt) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_comb begin
    prio_d = prio_q;
    tag_d  = TAG_NONE;
    if (a_gnt) begin
      prio_d = LAST_A;
      if (!a_we) tag_d = TAG_A;
    end else if (b_gnt) begin
      prio_d = LAST_B;
      if (!b_we) tag_d = TAG_B;
    end
  end

  // Reset leaves A to win the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= LAST_B;
      tag_q  <= TAG_NONE;
    end else begin
      prio_q <= prio_d;
      tag_q  <= tag_d;
    end
  end

  // rvalid follows the tag even during reset, so a read issued just
  // before reset still completes.
  assign a_rvalid = (tag_q == TAG_A);
  assign b_rvalid = (tag_q == TAG_B);
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// tb_sync_ram_arbiter: directed vectors for sync_ram_arbiter
// against a behavioural 4-word registered-read RAM.
module tb_sync_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_addr, b_addr;
  logic [17:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [17:0] a_rdata, b_rdata;
  logic        ram_ce, ram_we;
  logic [1:0]  ram_addr;
  logic [17:0] ram_wdata;
  logic [17:0] ram_rdata = '0;
  logic [17:0] mem [4];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  sync_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_gnt(input string t,
                         input logic ag, input logic bg,
                         input logic ce, input logic we,
                         input logic [1:0] ad,
                         input logic [17:0] wd);
    chk({t, ".a_gnt"}, 32'(a_gnt), 32'(ag));
    chk({t, ".b_gnt"}, 32'(b_gnt), 32'(bg));
    chk({t, ".ram_ce"}, 32'(ram_ce), 32'(ce));
    chk({t, ".ram_we"}, 32'(ram_we), 32'(we));
    chk({t, ".ram_addr"}, 32'(ram_addr), 32'(ad));
    chk({t, ".ram_wdata"}, 32'(ram_wdata), 32'(wd));
  endtask

  task automatic drive(input logic aq, input logic awe,
                       input logic [1:0] aad,
                       input logic [17:0] awd,
                       input logic bq, input logic bwe,
                       input logic [1:0] bad,
                       input logic [17:0] bwd);
    a_req = aq; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = bq; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 1, 0, 3, 0);
    chk_gnt("rst0", 0, 0, 0, 0, 0, 0);
    step();
    chk("rst0.a_rvalid", 32'(a_rvalid), 0);
    chk("rst0.b_rvalid", 32'(b_rvalid), 0);
    chk_gnt("rst1", 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // single writer then read-back of 0.5
    drive(1, 1, 1, 18'h00800, 0, 0, 0, 0);
    chk_gnt("wr1", 1, 0, 1, 1, 1, 18'h00800);
    step();
    chk("wr1.a_rvalid", 32'(a_rvalid), 0);
    chk("wr1.b_rvalid", 32'(b_rvalid), 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    chk_gnt("rd1", 1, 0, 1, 0, 1, 0);
    step();
    chk("rd1.a_rvalid", 32'(a_rvalid), 1);
    chk("rd1.a_rdata", 32'(a_rdata), 32'h00800);
    chk("rd1.b_rvalid", 32'(b_rvalid), 0);

    // preload addr0 and addr3
    drive(1, 1, 0, 18'h3F000, 0, 0, 0, 0);
    step();
    drive(1, 1, 3, 18'h01000, 0, 0, 0, 0);
    step();

    // interleaved reads, no idle cycle
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk_gnt("ilv_a", 1, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 3, 0);
    chk("ilv_a.a_rvalid", 32'(a_rvalid), 1);
    chk("ilv_a.a_rdata", 32'(a_rdata), 32'h3F000);
    chk_gnt("ilv_b", 0, 1, 1, 0, 3, 0);
    step();
    chk("ilv_b.b_rvalid", 32'(b_rvalid), 1);
    chk("ilv_b.b_rdata", 32'(b_rdata), 32'h01000);
    chk("ilv_b.a_rvalid", 32'(a_rvalid), 0);

    // B writes, A reads same address next cycle
    drive(0, 0, 0, 0, 1, 1, 2, 18'h20000);
    chk_gnt("raw_w", 0, 1, 1, 1, 2, 18'h20000);
    step();
    chk("raw_w.b_rvalid", 32'(b_rvalid), 0);
    drive(1, 0, 2, 0, 0, 0, 0, 0);
    chk_gnt("raw_r", 1, 0, 1, 0, 2, 0);
    step();
    chk("raw_r.a_rvalid", 32'(a_rvalid), 1);
    chk("raw_r.a_rdata", 32'(a_rdata), 32'h20000);

    // A was last: tie goes to B, then reset for 2 cycles
    drive(1, 0, 0, 0, 1, 0, 3, 0);
    chk_gnt("tie_b", 0, 1, 1, 0, 3, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk_gnt("mrst0", 0, 0, 0, 0, 0, 0);
    chk("mrst0.b_rvalid", 32'(b_rvalid), 1);
    chk("mrst0.b_rdata", 32'(b_rdata), 32'h01000);
    step();
    chk("mrst1.b_rvalid", 32'(b_rvalid), 0);
    chk("mrst1.a_rvalid", 32'(a_rvalid), 0);
    chk_gnt("mrst1", 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    #1;

    // sustained tie after reset alternates A,B,A,B
    for (int i = 0; i < 4; i++) begin
      logic ae;
      ae = (i % 2 == 0);
      chk_gnt($sformatf("alt%0d", i), ae, !ae, 1, 0,
              ae ? 2'd0 : 2'd3, 0);
      step();
      chk($sformatf("alt%0d.a_rvalid", i),
          32'(a_rvalid), 32'(ae));
      chk($sformatf("alt%0d.b_rvalid", i),
          32'(b_rvalid), 32'(!ae));
      chk($sformatf("alt%0d.rdata", i),
          32'(ae ? a_rdata : b_rdata),
          ae ? 32'h3F000 : 32'h01000);
    end

    // idle: nothing issued, priority kept (B last)
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk_gnt($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("idle%0d.a_rvalid", i),
          32'(a_rvalid), 0);
      chk($sformatf("idle%0d.b_rvalid", i),
          32'(b_rvalid), 0);
    end
    drive(1, 0, 0, 0, 1, 0, 3, 0);
    chk_gnt("post_idle", 1, 0, 1, 0, 0, 0);
    step();
    chk("post_idle.a_rvalid", 32'(a_rvalid), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
